dmem_arbiter: RTL and testbench

Shares the single data memory between the pipeline MEM stage (CPU port) and the RSA key/message loader (LD port). The CPU has fixed priority, and a starvation counter guarantees the loader progress. The block stalls the CPU while its access is pending and sequences fixed-latency reads through a small FSM. It sits between the MEM-stage signals produced from the decoded MemWrite/MemtoReg controls and the data RAM.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: fixed-priority CPU port, starvation-promoted loader port, fixed-latency reads.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stat_cpu_cnt,
  output logic [15:0]   stat_ld_cnt,
  output logic [15:0]   stat_stall_cnt
);
  localparam int WW = $clog2(RD_LAT + 1);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WW-1:0] LAT_W = WW'(RD_LAT);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);

  typedef enum logic {S_IDLE = 1'b0, S_RDWAIT = 1'b1} state_t;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        r_state, w_state_nxt;
  logic [WW-1:0] r_wait;
  logic [SW-1:0] r_starve;
  logic          r_owner_ld;
  logic [DW-1:0] r_cpu_rdata, r_ld_rdata;

  req_t w_cpu, w_ld, w_sel;
  logic w_promote, w_cpu_win, w_ld_win, w_issue, w_rd_issue, w_data_cyc;

  assign w_cpu = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign w_ld  = '{we: ld_we,  addr: ld_addr,  wdata: ld_wdata};

  // A starved loader beats the CPU for exactly one grant; the grant clears r_starve.
  assign w_promote  = (STARVE_LIMIT != 0) && ld_req && (r_starve == SLIM);
  assign w_cpu_win  = (r_state == S_IDLE) && cpu_req && !w_promote;
  assign w_ld_win   = (r_state == S_IDLE) && ld_req && (w_promote || !cpu_req);
  assign w_issue    = w_cpu_win || w_ld_win;
  assign w_sel      = w_ld_win ? w_ld : w_cpu;
  assign w_rd_issue = w_issue && !w_sel.we;
  assign w_data_cyc = (r_state == S_RDWAIT) && (r_wait == WW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_rd_issue) w_state_nxt = S_RDWAIT;
      S_RDWAIT: if (w_data_cyc) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes and grants are gated by rst_n so the RAM sees nothing while in reset.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ld_gnt     = 1'b0;
    cpu_rvalid = 1'b0;
    ld_rvalid  = 1'b0;
    cpu_stall  = 1'b0;
    if (rst_n) begin
      mem_en = w_issue;
      if (w_issue) begin
        mem_we    = w_sel.we;
        mem_addr  = w_sel.addr;
        mem_wdata = w_sel.wdata;
      end
      ld_gnt     = w_ld_win;
      cpu_rvalid = w_data_cyc && !r_owner_ld;
      ld_rvalid  = w_data_cyc && r_owner_ld;
      cpu_stall  = cpu_req && !((w_cpu_win && cpu_we) || cpu_rvalid);
    end
    cpu_rdata = cpu_rvalid ? mem_rdata : r_cpu_rdata;
    ld_rdata  = ld_rvalid  ? mem_rdata : r_ld_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait      <= '0;
      r_owner_ld  <= 1'b0;
      r_starve    <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else begin
      if (w_rd_issue) begin
        r_wait     <= LAT_W;
        r_owner_ld <= w_ld_win;
      end else if (r_state == S_RDWAIT) begin
        r_wait <= r_wait - WW'(1);
      end
      if (w_ld_win)                        r_starve <= '0;
      else if (ld_req && r_starve != SLIM) r_starve <= r_starve + SW'(1);
      if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (ld_rvalid)  r_ld_rdata  <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_cpu, r_stat_ld, r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cpu   <= '0;
      r_stat_ld    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_cpu_win) r_stat_cpu   <= r_stat_cpu + 16'd1;
      if (w_ld_win)  r_stat_ld    <= r_stat_ld + 16'd1;
      if (cpu_stall) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_cpu_cnt   = r_stat_cpu;
  assign stat_ld_cnt    = r_stat_ld;
  assign stat_stall_cnt = r_stat_stall;
`else
  assign stat_cpu_cnt   = '0;
  assign stat_ld_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3), directed scenarios plus
// randomized traffic checked against a cycle-count transaction model.
module tb_dmem_arbiter;
  localparam int NT = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cpu_req [NT], cpu_we [NT], ld_req [NT], ld_we [NT];
  logic [AW-1:0] cpu_addr [NT], ld_addr [NT];
  logic [DW-1:0] cpu_wdata [NT], ld_wdata [NT];
  logic          cpu_stall [NT], cpu_rvalid [NT], ld_gnt [NT], ld_rvalid [NT];
  logic          mem_en [NT], mem_we [NT];
  logic [AW-1:0] mem_addr [NT];
  logic [DW-1:0] cpu_rdata [NT], ld_rdata [NT], mem_wdata [NT], mem_rdata [NT];
  logic [15:0]   st_cpu [NT], st_ld [NT], st_stall [NT];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] rpipe [1:3];

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT), .STARVE_LIMIT(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_stall(cpu_stall[g]), .cpu_rdata(cpu_rdata[g]), .cpu_rvalid(cpu_rvalid[g]),
      .ld_req(ld_req[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]), .ld_wdata(ld_wdata[g]),
      .ld_gnt(ld_gnt[g]), .ld_rdata(ld_rdata[g]), .ld_rvalid(ld_rvalid[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .stat_cpu_cnt(st_cpu[g]), .stat_ld_cnt(st_ld[g]), .stat_stall_cnt(st_stall[g])
    );

    // RAM with LAT-cycle read pipeline; garbage on the bus when no read is returning
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
      rpipe[1] <= (mem_en[g] && !mem_we[g]) ? ram[mem_addr[g]] : $urandom;
      rpipe[2] <= rpipe[1];
      rpipe[3] <= rpipe[2];
    end
    assign mem_rdata[g] = rpipe[LAT];
  end

  task automatic idle_all();
    for (int d = 0; d < NT; d++) begin
      cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      ld_req[d]  = 1'b0; ld_we[d]  = 1'b0; ld_addr[d]  = '0; ld_wdata[d]  = '0;
    end
  endtask

  task automatic drv_cpu(input int d, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    cpu_req[d] = r; cpu_we[d] = w; cpu_addr[d] = a; cpu_wdata[d] = wd;
  endtask

  task automatic drv_ld(input int d, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    ld_req[d] = r; ld_we[d] = w; ld_addr[d] = a; ld_wdata[d] = wd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < NT; d++) begin
      drv_cpu(d, 1'b1, 1'b0, 10'h003, 32'h1111_2222);
      drv_ld(d, 1'b1, 1'b1, 10'h004, 32'h3333_4444);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NT; d++) begin
      checks++;
      if ({cpu_stall[d], mem_en[d], mem_we[d], ld_gnt[d], cpu_rvalid[d], ld_rvalid[d]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl d%0d: stall=%b en=%b we=%b gnt=%b crv=%b lrv=%b, want all 0",
                 d, cpu_stall[d], mem_en[d], mem_we[d], ld_gnt[d], cpu_rvalid[d], ld_rvalid[d]);
      end
      checks++;
      if (mem_addr[d] !== '0 || mem_wdata[d] !== '0 || cpu_rdata[d] !== '0 || ld_rdata[d] !== '0) begin
        errors++;
        $display("FAIL reset_data d%0d: addr=%h wd=%h crd=%h lrd=%h, want 0", d, mem_addr[d], mem_wdata[d], cpu_rdata[d], ld_rdata[d]);
      end
      checks++;
      if (st_cpu[d] !== 16'd0 || st_ld[d] !== 16'd0 || st_stall[d] !== 16'd0) begin
        errors++;
        $display("FAIL reset_stats d%0d: %0d %0d %0d, want 0 0 0", d, st_cpu[d], st_ld[d], st_stall[d]);
      end
    end
    idle_all();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_wr_rd();
    drv_cpu(0, 1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 10'h010 || mem_wdata[0] !== 32'hDEAD_BEEF || cpu_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr: en=%b we=%b addr=%h wd=%h stall=%b, want 1 1 010 deadbeef 0",
               mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], cpu_stall[0]);
    end
    step();
    drv_cpu(0, 1'b1, 1'b0, 10'h010, '0);
    @(negedge clk);
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b0 || mem_addr[0] !== 10'h010 || cpu_stall[0] !== 1'b1 || cpu_rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_issue: en=%b we=%b addr=%h stall=%b rv=%b, want 1 0 010 1 0",
               mem_en[0], mem_we[0], mem_addr[0], cpu_stall[0], cpu_rvalid[0]);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_rvalid[0] !== 1'b1 || cpu_rdata[0] !== 32'hDEAD_BEEF || cpu_stall[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_data: rv=%b rd=%h stall=%b en=%b, want 1 deadbeef 0 0",
               cpu_rvalid[0], cpu_rdata[0], cpu_stall[0], mem_en[0]);
    end
    step();
    drv_cpu(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (cpu_rvalid[0] !== 1'b0 || cpu_rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_rd_hold: rv=%b rd=%h, want 0 deadbeef", cpu_rvalid[0], cpu_rdata[0]);
    end
    step();
  endtask

  task automatic test_conflict();
    drv_cpu(0, 1'b1, 1'b1, 10'h001, 32'hA1A1_A1A1);
    drv_ld(0, 1'b1, 1'b1, 10'h002, 32'hB2B2_B2B2);
    @(negedge clk);
    checks++;
    if (mem_en[0] !== 1'b1 || mem_addr[0] !== 10'h001 || ld_gnt[0] !== 1'b0 || cpu_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL conflict_cpu: en=%b addr=%h gnt=%b stall=%b, want 1 001 0 0", mem_en[0], mem_addr[0], ld_gnt[0], cpu_stall[0]);
    end
    step();
    drv_cpu(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (ld_gnt[0] !== 1'b1 || mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 10'h002 || mem_wdata[0] !== 32'hB2B2_B2B2) begin
      errors++;
      $display("FAIL conflict_ld: gnt=%b en=%b we=%b addr=%h wd=%h, want 1 1 1 002 b2b2b2b2",
               ld_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    step();
    drv_ld(0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_starve();
    drv_ld(0, 1'b1, 1'b1, 10'h003, 32'h0000_0333);
    for (int k = 1; k <= 4; k++) begin
      drv_cpu(0, 1'b1, 1'b1, AW'(10'h100 + k), DW'(k));
      @(negedge clk);
      checks++;
      if (ld_gnt[0] !== 1'b0 || mem_addr[0] !== AW'(10'h100 + k) || cpu_stall[0] !== 1'b0) begin
        errors++;
        $display("FAIL starve_wait%0d: gnt=%b addr=%h stall=%b, want 0 %h 0", k, ld_gnt[0], mem_addr[0], cpu_stall[0], AW'(10'h100 + k));
      end
      step();
    end
    drv_cpu(0, 1'b1, 1'b1, 10'h105, 32'd5);
    @(negedge clk);
    checks++;
    if (ld_gnt[0] !== 1'b1 || mem_addr[0] !== 10'h003 || cpu_stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL starve_promote: gnt=%b addr=%h stall=%b, want 1 003 1", ld_gnt[0], mem_addr[0], cpu_stall[0]);
    end
    step();
    drv_ld(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (ld_gnt[0] !== 1'b0 || mem_addr[0] !== 10'h105 || cpu_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL starve_after: gnt=%b addr=%h stall=%b, want 0 105 0", ld_gnt[0], mem_addr[0], cpu_stall[0]);
    end
    step();
    drv_cpu(0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_rdlat3();
    drv_ld(1, 1'b1, 1'b1, 10'h020, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (ld_gnt[1] !== 1'b1 || mem_en[1] !== 1'b1 || mem_we[1] !== 1'b1) begin
      errors++;
      $display("FAIL lat3_ldwr: gnt=%b en=%b we=%b, want 1 1 1", ld_gnt[1], mem_en[1], mem_we[1]);
    end
    step();
    drv_ld(1, 1'b1, 1'b0, 10'h020, '0);
    @(negedge clk);
    checks++;
    if (ld_gnt[1] !== 1'b1 || mem_en[1] !== 1'b1 || mem_we[1] !== 1'b0 || mem_addr[1] !== 10'h020) begin
      errors++;
      $display("FAIL lat3_issue: gnt=%b en=%b we=%b addr=%h, want 1 1 0 020", ld_gnt[1], mem_en[1], mem_we[1], mem_addr[1]);
    end
    step();
    drv_ld(1, 1'b0, 1'b0, '0, '0);
    drv_cpu(1, 1'b1, 1'b1, 10'h030, 32'hC0C0_C0C0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_en[1] !== 1'b0 || ld_gnt[1] !== 1'b0 || cpu_stall[1] !== 1'b1 || ld_rvalid[1] !== (k == 3) ||
          (k == 3 && ld_rdata[1] !== 32'h1234_5678)) begin
        errors++;
        $display("FAIL lat3_wait T+%0d: en=%b gnt=%b stall=%b lrv=%b lrd=%h, want 0 0 1 %b 12345678",
                 k, mem_en[1], ld_gnt[1], cpu_stall[1], ld_rvalid[1], ld_rdata[1], (k == 3));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (mem_en[1] !== 1'b1 || mem_addr[1] !== 10'h030 || cpu_stall[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat3_next: en=%b addr=%h stall=%b, want 1 030 0", mem_en[1], mem_addr[1], cpu_stall[1]);
    end
    step();
    drv_cpu(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_midread();
    bit saw_rv = 1'b0;
    drv_cpu(1, 1'b1, 1'b0, 10'h020, '0);
    @(negedge clk);
    checks++;
    if (mem_en[1] !== 1'b1 || cpu_stall[1] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_issue: en=%b stall=%b, want 1 1", mem_en[1], cpu_stall[1]);
    end
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_stall[1], mem_en[1], ld_gnt[1], cpu_rvalid[1], ld_rvalid[1]} !== 5'b0 ||
        cpu_rdata[1] !== '0 || ld_rdata[1] !== '0 || mem_addr[1] !== '0) begin
      errors++;
      $display("FAIL midrst_outs: stall=%b en=%b gnt=%b crv=%b lrv=%b crd=%h lrd=%h addr=%h, want all 0",
               cpu_stall[1], mem_en[1], ld_gnt[1], cpu_rvalid[1], ld_rvalid[1], cpu_rdata[1], ld_rdata[1], mem_addr[1]);
    end
    repeat (3) begin
      @(negedge clk);
      if (cpu_rvalid[1] !== 1'b0) saw_rv = 1'b1;
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3 && cpu_rvalid[1] !== 1'b0) saw_rv = 1'b1;
      if (k == 0) begin
        checks++;
        if (mem_en[1] !== 1'b1 || mem_we[1] !== 1'b0 || cpu_stall[1] !== 1'b1) begin
          errors++;
          $display("FAIL midrst_reissue: en=%b we=%b stall=%b, want 1 0 1", mem_en[1], mem_we[1], cpu_stall[1]);
        end
      end
      if (k == 3) begin
        checks++;
        if (cpu_rvalid[1] !== 1'b1 || cpu_rdata[1] !== 32'h1234_5678 || cpu_stall[1] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_done: rv=%b rd=%h stall=%b, want 1 12345678 0", cpu_rvalid[1], cpu_rdata[1], cpu_stall[1]);
        end
      end
      step();
    end
    checks++;
    if (saw_rv) begin
      errors++;
      $display("FAIL midrst_norv: stray cpu_rvalid seen=1, want 0");
    end
    drv_cpu(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_stats();
    logic [15:0] e_c, e_l, e_s;
`ifdef DMEM_ARB_STATS_EN
    e_c = 16'd4; e_l = 16'd2; e_s = 16'd1;
`else
    e_c = 16'd0; e_l = 16'd0; e_s = 16'd0;
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv_cpu(0, 1'b1, 1'b1, AW'(10'h040 + k), DW'(k));
      step();
    end
    drv_cpu(0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      drv_ld(0, 1'b1, 1'b1, AW'(10'h050 + k), DW'(k));
      step();
    end
    drv_ld(0, 1'b0, 1'b0, '0, '0);
    drv_cpu(0, 1'b1, 1'b0, 10'h040, '0);
    step();
    step();
    drv_cpu(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (st_cpu[0] !== e_c || st_ld[0] !== e_l || st_stall[0] !== e_s) begin
      errors++;
      $display("FAIL stats: cpu=%0d ld=%0d stall=%0d, want %0d %0d %0d", st_cpu[0], st_ld[0], st_stall[0], e_c, e_l, e_s);
    end
    step();
  endtask

  // Transaction model: the port is free again lat+1 cycles after a read issue, read data
  // appears exactly lat cycles after issue, and the loader is promoted after 4 waiting cycles.
  task automatic test_random(input int d, input int lat, input int ncyc);
    logic [DW-1:0] emem [16];
    bit            valid [16];
    bit            cp = 1'b0, cw = 1'b0, lp = 1'b0, lw = 1'b0;
    logic [AW-1:0] ca = '0, la = '0, ex_addr;
    logic [DW-1:0] cd = '0, lwd = '0, ex_wd, rd_data = '0, ex_crd = '0, ex_lrd = '0;
    int            free_at = 0, data_at = -1, st = 0, win;
    int            n_cpu = 0, n_ld = 0, n_stall = 0;
    bit            own_ld = 1'b0, rvc, rvl, ex_en, ex_we, ex_stall;
    logic [15:0]   e_c, e_l, e_s;
    for (int i = 0; i < 16; i++) valid[i] = 1'b0;
    rst_n = 1'b0;
    idle_all();
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1'b1; ca = AW'($urandom_range(0, 15)); cd = $urandom; cw = 1'($urandom_range(0, 1));
        if (!valid[ca[3:0]]) cw = 1'b1;
      end
      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1'b1; la = AW'($urandom_range(0, 15)); lwd = $urandom; lw = 1'($urandom_range(0, 1));
        if (!valid[la[3:0]]) lw = 1'b1;
      end
      drv_cpu(d, cp, cw, ca, cd);
      drv_ld(d, lp, lw, la, lwd);

      rvc = (cyc == data_at) && !own_ld;
      rvl = (cyc == data_at) && own_ld;
      win = 0;
      if (cyc >= free_at) begin
        if (lp && st == 4) win = 2;
        else if (cp)       win = 1;
        else if (lp)       win = 2;
      end
      ex_en    = (win != 0);
      ex_we    = (win == 2) ? lw : cw;
      ex_addr  = (win == 2) ? la : ca;
      ex_wd    = (win == 2) ? lwd : cd;
      ex_stall = cp && !((win == 1) && cw) && !rvc;
      if (rvc) ex_crd = rd_data;
      if (rvl) ex_lrd = rd_data;

      @(negedge clk);
      checks++;
      if (mem_en[d] !== ex_en || (ex_en && (mem_we[d] !== ex_we || mem_addr[d] !== ex_addr || (ex_we && mem_wdata[d] !== ex_wd)))) begin
        errors++;
        $display("FAIL rnd_mem d%0d c%0d: en=%b we=%b addr=%h wd=%h, want %b %b %h %h",
                 d, cyc, mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], ex_en, ex_we, ex_addr, ex_wd);
      end
      checks++;
      if (ld_gnt[d] !== (win == 2)) begin
        errors++;
        $display("FAIL rnd_gnt d%0d c%0d: gnt=%b, want %b", d, cyc, ld_gnt[d], (win == 2));
      end
      checks++;
      if (cpu_stall[d] !== ex_stall) begin
        errors++;
        $display("FAIL rnd_stall d%0d c%0d: stall=%b, want %b", d, cyc, cpu_stall[d], ex_stall);
      end
      checks++;
      if (cpu_rvalid[d] !== rvc || cpu_rdata[d] !== ex_crd) begin
        errors++;
        $display("FAIL rnd_cpu_rd d%0d c%0d: rv=%b rd=%h, want %b %h", d, cyc, cpu_rvalid[d], cpu_rdata[d], rvc, ex_crd);
      end
      checks++;
      if (ld_rvalid[d] !== rvl || ld_rdata[d] !== ex_lrd) begin
        errors++;
        $display("FAIL rnd_ld_rd d%0d c%0d: rv=%b rd=%h, want %b %h", d, cyc, ld_rvalid[d], ld_rdata[d], rvl, ex_lrd);
      end

      if (win != 0) begin
        if (win == 1) n_cpu++; else n_ld++;
        if (ex_we) begin
          emem[ex_addr[3:0]] = ex_wd;
          valid[ex_addr[3:0]] = 1'b1;
        end else begin
          rd_data = emem[ex_addr[3:0]];
          own_ld  = (win == 2);
          data_at = cyc + lat;
          free_at = cyc + lat + 1;
        end
      end
      if (ex_stall) n_stall++;
      if (win == 2)            st = 0;
      else if (lp && st < 4)   st++;
      if ((win == 1 && cw) || rvc) cp = 1'b0;
      if (win == 2) lp = 1'b0;
      step();
    end
`ifdef DMEM_ARB_STATS_EN
    e_c = 16'(n_cpu); e_l = 16'(n_ld); e_s = 16'(n_stall);
`else
    e_c = 16'd0; e_l = 16'd0; e_s = 16'd0;
`endif
    @(negedge clk);
    checks++;
    if (st_cpu[d] !== e_c || st_ld[d] !== e_l || st_stall[d] !== e_s) begin
      errors++;
      $display("FAIL rnd_stats d%0d: cpu=%0d ld=%0d stall=%0d, want %0d %0d %0d", d, st_cpu[d], st_ld[d], st_stall[d], e_c, e_l, e_s);
    end
    idle_all();
    step();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_cpu_wr_rd();
    test_conflict();
    test_starve();
    test_rdlat3();
    test_reset_midread();
    test_stats();
    test_random(0, 1, 400);
    test_random(1, 3, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
